string_serializer: RTL and testbench
====================================

STRING_SERIALIZER -- requirements
Module: string_serializer

Interface
REQ-001 SHALL have parameter T0H_CYCLES, default 8, giving the high time of a '0' bit in clk cycles (0.40 us at 20 MHz).
REQ-002 SHALL have parameter T1H_CYCLES, default 16, giving the high time of a '1' bit in clk cycles (0.80 us).
REQ-003 SHALL have parameter TBIT_CYCLES, default 25, giving the total period of one bit in clk cycles (1.25 us).
REQ-004 SHALL have parameter TLATCH_CYCLES, default 1200, giving the low time of the frame latch in clk cycles (60 us).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, 20 MHz string clock domain.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port pixel_data, input, 24 bits: pixel word, transmitted MSB (bit 23) first.
REQ-008 SHALL have port pixel_valid, input, 1 bit: pixel_data is valid.
REQ-009 SHALL have port pixel_ready, output, 1 bit: pixel accepted on a clk edge where pixel_valid and pixel_ready are both high.
REQ-010 SHALL have port frame_end, input, 1 bit: single-cycle pulse requesting the latch period after the final pixel.
REQ-011 SHALL have port busy, output, 1 bit: high when the block is not in IDLE.
REQ-012 SHALL have port led_sdi, output, 1 bit: registered single-wire LED data.

Function
REQ-013 SHALL implement exactly three states: IDLE, SHIFT and LATCH.
REQ-014 SHALL drive pixel_ready high in IDLE when latch_pending=0, and in the final cycle of bit 0 in SHIFT when latch_pending=0; pixel_ready SHALL be low otherwise.
REQ-015 SHALL, on acceptance in IDLE, load pixel_data into the shift register, set bit index=23 and cycle count=0, and enter SHIFT; led_sdi SHALL go high on the next cycle (latency 1).
REQ-016 SHALL, in SHIFT, hold led_sdi high for T0H_CYCLES (current bit=0) or T1H_CYCLES (current bit=1) cycles, then low until the cycle count reaches TBIT_CYCLES, giving exactly TBIT_CYCLES per bit.
REQ-017 SHALL, at the end of each bit period, reset the cycle count to 0 and decrement the bit index; after bit 0 the pixel is complete.
REQ-018 SHALL, at pixel completion with a pixel accepted in the same cycle, load the new pixel and continue in SHIFT without any gap between bits.
REQ-019 SHALL, at pixel completion with no pixel accepted, go to LATCH if latch_pending=1 and otherwise to IDLE.
REQ-020 SHALL set the sticky latch_pending flag on a frame_end pulse in any state except LATCH.
REQ-021 SHALL ignore a frame_end pulse that occurs in LATCH.
REQ-022 SHALL, in IDLE with latch_pending=1, enter LATCH on the next cycle.
REQ-023 SHALL, in IDLE with pixel_valid=1 and frame_end=1 in the same cycle, accept the pixel and set latch_pending, so the latch follows that pixel.
REQ-024 SHALL, on entering LATCH, clear latch_pending and hold led_sdi=0 and pixel_ready=0 for TLATCH_CYCLES cycles, then return to IDLE.
REQ-025 SHALL size the cycle counter as clog2(max(TBIT_CYCLES,TLATCH_CYCLES)+1) bits and the bit index as 5 bits; there SHALL be no wrap-around within a period.
REQ-026 SHALL require 1<=T0H_CYCLES<T1H_CYCLES<TBIT_CYCLES; this SHALL be enforced by an elaboration-time assertion.
REQ-027 SHALL keep led_sdi glitch-free by driving it straight from a flop.
REQ-028 SHALL keep pixel_ready combinational from registered state only, with no path from pixel_valid to pixel_ready.

Reset
REQ-029 SHALL, while reset is high, force state=IDLE, latch_pending=0, led_sdi=0, shift register=0, and both counters=0.
REQ-030 SHALL, after the first reset clock edge, present pixel_ready=1, busy=0 and led_sdi=0.
REQ-031 SHALL abort any SHIFT or LATCH when reset is asserted mid-operation, with led_sdi low on the cycle after the reset edge and no partial bit resumed.

Verification
REQ-032 SHALL cover: one pixel 0xFF0000, then idle -> 8 bits of 16 high/9 low, then 16 bits of 8 high/17 low; 600 cycles total; then IDLE, busy=0.
REQ-033 SHALL cover: two pixels 0xAAAAAA and 0x555555 with pixel_valid held high -> second accepted in the last cycle of the first; 1200 cycles with no gap; bit pattern alternates throughout.
REQ-034 SHALL cover: one pixel with frame_end pulsed mid-pixel -> pixel_ready=0 at completion, then exactly 1200 cycles of led_sdi=0, then IDLE.
REQ-035 SHALL cover: frame_end and pixel_valid in the same IDLE cycle -> pixel (600 cycles) followed by LATCH (1200 cycles).
REQ-036 SHALL cover: reset asserted at cycle 300 of a pixel -> led_sdi=0 next cycle; pixel_ready=1 one cycle after reset deasserts; a new pixel then transmits correctly.
REQ-037 SHALL cover: frame_end pulsed during LATCH -> ignored; exactly one 1200-cycle latch.

Source files
------------

// File: rtl/string_serializer_if.sv
// Pixel stream handshake between a pixel source and string_serializer.
//   pixel_data  : 24-bit pixel word, transmitted MSB (bit 23) first
//   pixel_valid : source has a pixel on pixel_data
//   pixel_ready : serializer accepts the pixel on a clk edge where
//                 pixel_valid and pixel_ready are both high
// master = pixel source, slave = serializer.
interface string_serializer_if;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (
        output pixel_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/string_serializer.sv
// Single-wire LED string serializer.
// Each accepted 24-bit pixel is sent MSB first. Every bit lasts
// TBIT_CYCLES clocks: led_sdi is high for T0H_CYCLES ('0') or T1H_CYCLES
// ('1') and low for the rest of the bit. A frame_end pulse arms a sticky
// latch request; once the current pixel finishes, led_sdi is held low for
// TLATCH_CYCLES clocks so the string latches the frame.
// Ports:
//   clk       : single clock (20 MHz string domain)
//   reset     : synchronous, active-high
//   pix       : pixel stream (slave side of string_serializer_if)
//   frame_end : single-cycle pulse requesting the latch after the last pixel
//   busy      : high whenever the block is not idle
//   led_sdi   : registered LED data line
module string_serializer #(
    parameter int T0H_CYCLES    = 8,
    parameter int T1H_CYCLES    = 16,
    parameter int TBIT_CYCLES   = 25,
    parameter int TLATCH_CYCLES = 1200
) (
    input  logic                 clk,
    input  logic                 reset,
    string_serializer_if.slave   pix,
    input  logic                 frame_end,
    output logic                 busy,
    output logic                 led_sdi
);

    localparam int CNT_MAX = (TBIT_CYCLES > TLATCH_CYCLES) ? TBIT_CYCLES : TLATCH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] T0H_C       = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_C       = CW'(T1H_CYCLES);
    localparam logic [CW-1:0] TBIT_LAST   = CW'(TBIT_CYCLES - 1);
    localparam logic [CW-1:0] TLATCH_LAST = CW'(TLATCH_CYCLES - 1);

    generate
        if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < TBIT_CYCLES
              && TLATCH_CYCLES >= 1)) begin : g_bad_timing
            $error("string_serializer: need 1 <= T0H < T1H < TBIT and TLATCH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          latch_pending_q, latch_pending_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;

    logic          pixel_done;
    logic          ready;
    logic          accept;
    logic [CW-1:0] high_time_d;

    // Last cycle of bit 0: the pixel completes on the coming edge, so a
    // new pixel can be taken here to keep the bit stream gapless.
    assign pixel_done = (state_q == SHIFT) && (cnt_q == TBIT_LAST) && (bit_idx_q == 5'd0);

    // Derived from registered state only; pixel_valid never feeds back here.
    assign ready  = !latch_pending_q && ((state_q == IDLE) || pixel_done);
    assign accept = pix.pixel_valid && ready;

    always_comb begin
        state_d         = state_q;
        latch_pending_d = latch_pending_q;
        shreg_d         = shreg_q;
        bit_idx_d       = bit_idx_q;
        cnt_d           = cnt_q;

        // A frame_end seen while latching is already being served.
        if (frame_end && (state_q != LATCH)) begin
            latch_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (latch_pending_q) begin
                    state_d         = LATCH;
                    latch_pending_d = 1'b0;
                    cnt_d           = '0;
                end else if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = pix.pixel_data;
                    bit_idx_d = 5'd23;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == TBIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == 5'd0) begin
                        if (accept) begin
                            shreg_d   = pix.pixel_data;
                            bit_idx_d = 5'd23;
                        end else if (latch_pending_q) begin
                            state_d         = LATCH;
                            latch_pending_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        // Current bit always sits in shreg[23].
                        bit_idx_d = bit_idx_q - 5'd1;
                        shreg_d   = {shreg_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == TLATCH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // led_sdi is computed from next-state values so the flop output
        // lines up with the cycle the counter describes (latency 1 from accept).
        high_time_d = shreg_d[23] ? T1H_C : T0H_C;
        led_d       = (state_d == SHIFT) && (cnt_d < high_time_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            latch_pending_q <= 1'b0;
            shreg_q         <= '0;
            bit_idx_q       <= '0;
            cnt_q           <= '0;
            led_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            latch_pending_q <= latch_pending_d;
            shreg_q         <= shreg_d;
            bit_idx_q       <= bit_idx_d;
            cnt_q           <= cnt_d;
            led_q           <= led_d;
        end
    end

    assign pix.pixel_ready = ready;
    assign busy            = (state_q != IDLE);
    assign led_sdi         = led_q;

endmodule

// File: tb/tb_string_serializer.sv
// Self-checking bench for string_serializer (default timing parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_string_serializer;

    localparam int T0H    = 8;
    localparam int T1H    = 16;
    localparam int TBIT   = 25;
    localparam int TLATCH = 1200;

    logic clk;
    logic reset;
    logic frame_end;
    logic busy;
    logic led_sdi;

    string_serializer_if pix ();

    string_serializer #(
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .TBIT_CYCLES  (TBIT),
        .TLATCH_CYCLES(TLATCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pix      (pix),
        .frame_end(frame_end),
        .busy     (busy),
        .led_sdi  (led_sdi)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] data;
        int          exp_highs;   // total led_sdi-high cycles over the pixel
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Samples nbits*TBIT cycles starting at the current falling edge and
    // decodes bits from high-pulse widths. bad counts windows whose pulse is
    // not a single leading high run of T0H or T1H cycles. pixel_valid is
    // dropped right after it is accepted; frame_end is pulsed at index fe_at.
    task automatic capture(input int nbits, input int fe_at,
                           output logic [47:0] word, output int highs,
                           output int bad, output int rdy_cnt, output int acc_idx);
        int   h;
        int   i;
        logic prev;
        word = '0; highs = 0; bad = 0; rdy_cnt = 0; acc_idx = -1;
        for (int b = 0; b < nbits; b++) begin
            h = 0;
            prev = 1'b1;
            for (int c = 0; c < TBIT; c++) begin
                i = b * TBIT + c;
                if (led_sdi) begin
                    h++;
                    if (!prev) bad++;
                end
                prev = led_sdi;
                if (pix.pixel_ready) rdy_cnt++;
                if (pix.pixel_ready && pix.pixel_valid) acc_idx = i;
                if (i == fe_at) frame_end = 1'b1;
                @(negedge clk);
                frame_end = 1'b0;
                if (acc_idx == i) pix.pixel_valid = 1'b0;
            end
            highs += h;
            if (h != T0H && h != T1H) bad++;
            word = {word[46:0], (h == T1H)};
        end
    endtask

    // Waits (bounded) for busy, then counts busy cycles; frame_end pulsed at fe_at.
    task automatic measure_latch(input int fe_at, output int len, output int led_hi);
        len = 0; led_hi = 0;
        for (int w = 0; w < 10 && !busy; w++) @(negedge clk);
        while (busy && len < 3000) begin
            if (led_sdi) led_hi++;
            if (len == fe_at) frame_end = 1'b1;
            len++;
            @(negedge clk);
            frame_end = 1'b0;
        end
    endtask

    // Presents one pixel in IDLE; returns on the falling edge after acceptance.
    task automatic send_pixel(input logic [23:0] d, input logic fe, input string name);
        pix.pixel_data  = d;
        pix.pixel_valid = 1'b1;
        frame_end       = fe;
        chk({name, " ready_before"}, {63'd0, pix.pixel_ready}, 64'd1);
        @(negedge clk);
        pix.pixel_valid = 1'b0;
        frame_end       = 1'b0;
        chk({name, " led_latency1"}, {63'd0, led_sdi}, 64'd1);
    endtask

    logic [47:0] word;
    int highs, bad, rdy, acc, len, ledhi, busy_cnt;

    initial begin
        vecs[0] = '{24'hFF0000, 256};
        vecs[1] = '{24'hAAAAAA, 288};
        vecs[2] = '{24'h000000, 192};
        vecs[3] = '{24'hFFFFFF, 384};
        vecs[4] = '{24'h800001, 208};

        reset = 1'b1; frame_end = 1'b0;
        pix.pixel_valid = 1'b0; pix.pixel_data = '0;
        repeat (3) @(negedge clk);
        chk("reset led", {63'd0, led_sdi}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset ready", {63'd0, pix.pixel_ready}, 64'd1);

        // Single pixels from the table.
        for (int v = 0; v < 5; v++) begin
            send_pixel(vecs[v].data, 1'b0, $sformatf("vec%0d", v));
            capture(24, -1, word, highs, bad, rdy, acc);
            chk($sformatf("vec%0d word", v), {40'd0, word[23:0]}, {40'd0, vecs[v].data});
            chk($sformatf("vec%0d highs", v), 64'(highs), 64'(vecs[v].exp_highs));
            chk($sformatf("vec%0d shape", v), 64'(bad), 64'd0);
            chk($sformatf("vec%0d ready_cnt", v), 64'(rdy), 64'd1);
            chk($sformatf("vec%0d idle_busy", v), {63'd0, busy}, 64'd0);
            chk($sformatf("vec%0d idle_led", v), {63'd0, led_sdi}, 64'd0);
        end

        // Back-to-back pixels with pixel_valid held: second taken in cycle 599.
        pix.pixel_data = 24'hAAAAAA; pix.pixel_valid = 1'b1;
        @(negedge clk);
        pix.pixel_data = 24'h555555;
        chk("b2b ready_in_shift", {63'd0, pix.pixel_ready}, 64'd0);
        capture(48, -1, word, highs, bad, rdy, acc);
        chk("b2b word", {16'd0, word}, {16'd0, 48'hAAAAAA555555});
        chk("b2b accept_idx", 64'(acc), 64'd599);
        chk("b2b shape", 64'(bad), 64'd0);
        chk("b2b busy_end", {63'd0, busy}, 64'd0);

        // frame_end mid-pixel: no ready at completion, then one latch.
        send_pixel(24'hC3A50F, 1'b0, "fe_mid");
        capture(24, 300, word, highs, bad, rdy, acc);
        chk("fe_mid word", {40'd0, word[23:0]}, {40'd0, 24'hC3A50F});
        chk("fe_mid ready_cnt", 64'(rdy), 64'd0);
        measure_latch(-1, len, ledhi);
        chk("fe_mid latch_len", 64'(len), 64'd1200);
        chk("fe_mid latch_led", 64'(ledhi), 64'd0);
        chk("fe_mid ready_after", {63'd0, pix.pixel_ready}, 64'd1);

        // frame_end and pixel_valid in the same IDLE cycle.
        send_pixel(24'h123456, 1'b1, "fe_same");
        capture(24, -1, word, highs, bad, rdy, acc);
        chk("fe_same word", {40'd0, word[23:0]}, {40'd0, 24'h123456});
        chk("fe_same shape", 64'(bad), 64'd0);
        measure_latch(-1, len, ledhi);
        chk("fe_same latch_len", 64'(len), 64'd1200);

        // Reset at cycle 300 of a pixel (led high there for 0xFFFFFF).
        send_pixel(24'hFFFFFF, 1'b0, "rst_mid");
        repeat (300) @(negedge clk);
        chk("rst_mid led_before", {63'd0, led_sdi}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid led_after", {63'd0, led_sdi}, 64'd0);
        chk("rst_mid busy_after", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid ready", {63'd0, pix.pixel_ready}, 64'd1);
        send_pixel(24'h0F0F0F, 1'b0, "rst_new");
        capture(24, -1, word, highs, bad, rdy, acc);
        chk("rst_new word", {40'd0, word[23:0]}, {40'd0, 24'h0F0F0F});
        chk("rst_new shape", 64'(bad), 64'd0);

        // frame_end during LATCH is ignored: exactly one latch.
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("fe_idle ready_pending", {63'd0, pix.pixel_ready}, 64'd0);
        measure_latch(100, len, ledhi);
        chk("fe_latch len", 64'(len), 64'd1200);
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("fe_latch no_second", 64'(busy_cnt), 64'd0);
        chk("fe_latch ready", {63'd0, pix.pixel_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #10ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
